vid_pattern_gen: RTL and testbench

- Video source for the vid_io pixel path. Generates raster timing (hsync, vsync, VDE) and 24-bit test-pattern pixels.
- Drives the same vid_io interface that downstream pixel filters (colour change, greyscale, invert) consume.
- Lets the filter chain be exercised without the camera path. Pattern is selected by board switches and changes only on frame boundaries.

---
 rtl/vid_pattern_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_vid_pattern_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vid_pattern_gen.sv
// Raster timing and test-pattern source for the vid_io pixel path.
// Optional macro VID_PATTERN_SCROLL_EN scrolls every pattern left by one pixel per frame.
module vid_pattern_gen #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int SYNC_POL   = 1,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_en,
    input  logic [3:0]            sw,
    output logic [DATA_WIDTH-1:0] o_vid_data,
    output logic                  o_vid_hsync,
    output logic                  o_vid_vsync,
    output logic                  o_vid_VDE,
    output logic                  o_sof
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = DATA_WIDTH / 3;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] X_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SP       = (SYNC_POL != 0);
    localparam logic [CW-1:0] MID      = {1'b1, {(CW-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] bar_rgb(input logic [3:0] idx);
        logic r, g, b;
        r = ~idx[1];
        g = ~idx[2];
        b = ~idx[0];
        if (idx[3]) begin
            r = 1'b0;
            g = 1'b0;
            b = 1'b0;
        end
        return {{CW{r}}, {CW{b}}, {CW{g}}};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] swap_rb(input logic [DATA_WIDTH-1:0] p);
        return {p[2*CW-1:CW], p[3*CW-1:2*CW], p[CW-1:0]};
    endfunction

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [HW-1:0] bar_px_q, bar_px_d;
    logic [3:0]    bar_idx_q, bar_idx_d;
    logic [3:0]    sel_q;
    logic [HW-1:0] x_cur;
    logic [HW-1:0] ld_px;
    logic [3:0]    ld_idx;
    logic          h_wrap, v_wrap, at_origin;

    assign h_wrap    = (hcount_q == H_LAST);
    assign v_wrap    = (vcount_q == V_LAST);
    assign at_origin = (hcount_q == '0) && (vcount_q == '0);

`ifdef VID_PATTERN_SCROLL_EN
    logic [10:0]   frame_cnt_q, frame_cnt_d;
    logic [HW-1:0] xstart_q, xstart_d, xcount_q, xcount_d;
    logic [HW-1:0] spx_q, spx_d;
    logic [3:0]    sidx_q, sidx_d;

    // Line-start coordinate and its bar position track (frame_cnt mod H_ACTIVE) incrementally.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        xstart_d    = xstart_q;
        spx_d       = spx_q;
        sidx_d      = sidx_q;
        xcount_d    = xcount_q;
        if (i_en && h_wrap && v_wrap) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (frame_cnt_q == 11'h7FF || xstart_q == X_LAST) begin
                xstart_d = '0;
                spx_d    = '0;
                sidx_d   = '0;
            end else begin
                xstart_d = xstart_q + 1'b1;
                if (spx_q == BAR_LAST) begin
                    spx_d  = '0;
                    sidx_d = sidx_q + 1'b1;
                end else begin
                    spx_d = spx_q + 1'b1;
                end
            end
        end
        if (i_en) begin
            if (h_wrap) xcount_d = xstart_d;
            else        xcount_d = (xcount_q == X_LAST) ? '0 : xcount_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frame_cnt_q <= '0;
            xstart_q    <= '0;
            spx_q       <= '0;
            sidx_q      <= '0;
            xcount_q    <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            xstart_q    <= xstart_d;
            spx_q       <= spx_d;
            sidx_q      <= sidx_d;
            xcount_q    <= xcount_d;
        end
    end

    assign x_cur  = xcount_q;
    assign ld_px  = spx_d;
    assign ld_idx = sidx_d;
`else
    assign x_cur  = hcount_q;
    assign ld_px  = '0;
    assign ld_idx = '0;
`endif

    // Bar index follows x through a pixel-in-bar counter instead of dividing.
    always_comb begin
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (i_en) begin
            if (h_wrap) begin
                hcount_d  = '0;
                vcount_d  = v_wrap ? '0 : vcount_q + 1'b1;
                bar_px_d  = ld_px;
                bar_idx_d = ld_idx;
            end else begin
                hcount_d = hcount_q + 1'b1;
                if (x_cur == X_LAST) begin
                    bar_px_d  = '0;
                    bar_idx_d = '0;
                end else if (bar_px_q == BAR_LAST) begin
                    bar_px_d  = '0;
                    bar_idx_d = bar_idx_q + 1'b1;
                end else begin
                    bar_px_d = bar_px_q + 1'b1;
                end
            end
        end
    end

    logic [3:0]            pat_sw;
    logic [DATA_WIDTH-1:0] pix;
    logic                  active, hs, vs;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  vde_d, vde_q, hs_d, hs_q, vs_d, vs_q, sof_d, sof_q;

    assign active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    assign hs     = (hcount_q >= HS_START) && (hcount_q < HS_END);
    assign vs     = (vcount_q >= VS_START) && (vcount_q < VS_END);
    // The first pixel of a frame already uses the switch value being latched on that edge.
    assign pat_sw = at_origin ? sw : sel_q;

    always_comb begin
        case (pat_sw[1:0])
            2'b00:   pix = bar_rgb(bar_idx_q);
            2'b01:   pix = (x_cur[CHECK_LOG2] ^ vcount_q[CHECK_LOG2]) ? '0 : '1;
            2'b10:   pix = {3{CW'(x_cur)}};
            default: pix = {3{MID}};
        endcase
        if (pat_sw[2]) pix = swap_rb(pix);
        if (pat_sw[3]) pix = ~pix;
    end

    always_comb begin
        data_d = '0;
        vde_d  = 1'b0;
        hs_d   = ~SP;
        vs_d   = ~SP;
        sof_d  = 1'b0;
        if (i_en) begin
            vde_d = active;
            hs_d  = hs ? SP : ~SP;
            vs_d  = vs ? SP : ~SP;
            sof_d = at_origin;
            if (active) data_d = pix;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hcount_q  <= '0;
            vcount_q  <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            vde_q     <= 1'b0;
            hs_q      <= ~SP;
            vs_q      <= ~SP;
            sof_q     <= 1'b0;
        end else begin
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            if (i_en && at_origin) sel_q <= sw;
            data_q    <= data_d;
            vde_q     <= vde_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            sof_q     <= sof_d;
        end
    end

    assign o_vid_data  = data_q;
    assign o_vid_VDE   = vde_q;
    assign o_vid_hsync = hs_q;
    assign o_vid_vsync = vs_q;
    assign o_sof       = sof_q;
endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen with a 24x8 raster (16x4 active).
module tb_vid_pattern_gen;
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_en;
    logic [3:0]  sw;
    logic [23:0] data;
    logic        hs, vs, vde, sof;

    always #5 clk = ~clk;

    vid_pattern_gen #(
        .DATA_WIDTH(24), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_POL(1), .CHECK_LOG2(2)
    ) dut (
        .clk(clk), .n_rst(n_rst), .i_en(i_en), .sw(sw),
        .o_vid_data(data), .o_vid_hsync(hs), .o_vid_vsync(vs),
        .o_vid_VDE(vde), .o_sof(sof)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                                 24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};

    function automatic logic [23:0] exp_pix(input int h, input int v, input logic [3:0] s);
        logic [23:0] p;
        logic [7:0]  hb;
        hb = 8'(h);
        case (s[1:0])
            2'd0:    p = bar_tab[h/2];
            2'd1:    p = ((((h >> 2) ^ (v >> 2)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
            2'd2:    p = {hb, hb, hb};
            default: p = 24'h808080;
        endcase
        if (s[2]) p = {p[15:8], p[23:16], p[7:0]};
        if (s[3]) p = ~p;
        return p;
    endfunction

    // Raster position the next enabled edge will present, plus the latched select.
    int         mh, mv;
    logic [3:0] msel;
    bit         track;
    int         vde_cnt, hs_cnt, vs_cnt, sof_cnt, run, cyc, last_sof;

    task automatic step();
        logic [23:0] ed;
        logic        ev, eh, evs, es;
        logic [3:0]  s;
        @(posedge clk);
        if (i_en) begin
            es  = (mh == 0) && (mv == 0);
            s   = es ? sw : msel;
            if (es) msel = sw;
            ev  = (mh < HA) && (mv < VA);
            eh  = (mh >= HA + HFP) && (mh < HA + HFP + HSY);
            evs = (mv >= VA + VFP) && (mv < VA + VFP + VSY);
            ed  = ev ? exp_pix(mh, mv, s) : 24'h0;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end else begin
            es = 1'b0; ev = 1'b0; eh = 1'b0; evs = 1'b0; ed = 24'h0;
        end
        @(negedge clk);
        check("vde", vde, ev);
        check("hsync", hs, eh);
        check("vsync", vs, evs);
        check("sof", sof, es);
        check("data", data, ed);
        if (track) begin
            cyc++;
            if (vde) vde_cnt++;
            if (hs)  hs_cnt++;
            if (vs)  vs_cnt++;
            if (sof) begin
                if (last_sof >= 0) check("sof_period", cyc - last_sof, HT * VT);
                last_sof = cyc;
                sof_cnt++;
            end
            if (vde) run++;
            else begin
                if (run != 0) check("vde_run", run, HA);
                run = 0;
            end
        end
    endtask

    task automatic goto(input int h, input int v);
        int guard;
        guard = 0;
        while (!(mh == h && mv == v) && guard < 500) begin
            step();
            guard++;
        end
        check("goto_bound", guard < 500, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int cnt7f;
        n_rst = 1'b0; i_en = 1'b0; sw = 4'b0000;
        mh = 0; mv = 0; msel = 4'b0000; track = 1'b0;
        vde_cnt = 0; hs_cnt = 0; vs_cnt = 0; sof_cnt = 0; run = 0; cyc = 0; last_sof = -1;
        repeat (3) @(negedge clk);
        check("rst_data", data, 24'h0);
        check("rst_vde", vde, 0);
        check("rst_hsync", hs, 0);
        check("rst_vsync", vs, 0);
        check("rst_sof", sof, 0);

        // Two frames of colour bars with timing bookkeeping
        n_rst = 1'b1; i_en = 1'b1;
        track = 1'b1;
        repeat (2 * HT * VT) step();
        track = 1'b0;
        check("vde_total", vde_cnt, 2 * HA * VA);
        check("hs_total", hs_cnt, 2 * VT * HSY);
        check("vs_total", vs_cnt, 2 * VSY * HT);
        check("sof_total", sof_cnt, 2);

        // Mid-frame switch change only takes effect at the next frame
        repeat (50) step();
        sw = 4'b0001;
        goto(0, 0);
        step();
        check("chk_first_px", data, 24'hFFFFFF);
        goto(4, 0);
        step();
        check("chk_black_sq", data, 24'h000000);

        sw = 4'b1010;
        goto(0, 0);
        goto(5, 0);
        step();
        check("ramp_swap_inv", data, 24'hFAFAFA);

        sw = 4'b1011;
        goto(0, 0);
        cnt7f = 0;
        repeat (HT * VT) begin
            step();
            if (vde && data == 24'h7F7F7F) cnt7f++;
        end
        check("grey_inv_count", cnt7f, HA * VA);

        // Asynchronous reset between clock edges, mid-line
        goto(6, 1);
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        check("async_rst_data", data, 24'h0);
        check("async_rst_vde", vde, 0);
        check("async_rst_hsync", hs, 0);
        check("async_rst_vsync", vs, 0);
        @(negedge clk);
        mh = 0; mv = 0; msel = 4'b0000;
        n_rst = 1'b1;
        step();
        check("sof_after_rst", sof, 1);
        check("vde_after_rst", vde, 1);

        // Enable drop holds the raster position
        sw = 4'b0000;
        goto(0, 0);
        goto(7, 2);
        i_en = 1'b0;
        repeat (10) step();
        i_en = 1'b1;
        step();
        check("resume_px", data, 24'h0000FF);
        check("resume_vde", vde, 1);
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
